// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions NUM_BTN raw, active-low, bouncing push-buttons into clean levels
// and single-cycle events (press, release, long-press) for the LED pattern
// logic. Each button has its own 2-flop synchronizer, a shared debounce/hold
// counter and a 5-state FSM. Everything runs on clk_50M.
//
// Ports:
//   clk_50M        in   1        50 MHz system clock
//   rst_n          in   1        asynchronous, active-low reset
//   btn_n          in   NUM_BTN  raw buttons, asynchronous, 0 = pressed
//   btn_level      out  NUM_BTN  debounced state, 1 = pressed
//   press_pulse    out  NUM_BTN  1-cycle pulse when a press is accepted
//   release_pulse  out  NUM_BTN  1-cycle pulse when a release is accepted
//   long_pulse     out  NUM_BTN  1-cycle pulse once a press is held LONG_CYCLES
//
// Event protocol: there is no handshake. A pulse is a registered, one-cycle
// strobe that the consumer must sample on the clock edge following its rise;
// it is never held or repeated, and at most one of the three pulses is high
// for a given button in any cycle.
//
// Debug visibility: the per-button FSM state is the register `state` inside
// each g_btn[i] generate scope.
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse
);

    // One counter serves both the debounce and the long-press timer, so it is
    // sized for the larger of the two terminal counts.
    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES
                                                                : LONG_CYCLES;
    localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,  // released, level 0
        ST_ARM_P   = 3'd1,  // press seen, waiting for it to stay stable
        ST_PRESSED = 3'd2,  // press accepted, long timer running
        ST_HELD    = 3'd3,  // long pulse already issued for this press
        ST_ARM_R   = 3'd4   // release seen, waiting for it to stay stable
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronizer. Resets to 1 so that a released button looks released
    // immediately after reset.
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-button FSM and counter.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn

        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          long_fired;
        logic          long_fired_nxt;
        logic          level_q;
        logic          level_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          release_q;
        logic          release_nxt;
        logic          long_q;
        logic          long_nxt;
        logic          pressed;

        // Only the second synchronizer flop is ever looked at.
        assign pressed = ~sync2[g];

        always_comb begin
            state_nxt      = state;
            cnt_nxt        = cnt;
            long_fired_nxt = long_fired;
            level_nxt      = level_q;
            press_nxt      = 1'b0;
            release_nxt    = 1'b0;
            long_nxt       = 1'b0;

            case (state)
                ST_IDLE: begin
                    level_nxt = 1'b0;
                    if (pressed) begin
                        state_nxt = ST_ARM_P;
                        cnt_nxt   = '0;
                    end
                end

                ST_ARM_P: begin
                    if (!pressed) begin
                        // Glitch shorter than the debounce window: drop it.
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt      = ST_PRESSED;
                        level_nxt      = 1'b1;
                        press_nxt      = 1'b1;
                        cnt_nxt        = '0;
                        long_fired_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end

                ST_PRESSED: begin
                    if (!pressed) begin
                        state_nxt = ST_ARM_R;
                        cnt_nxt   = '0;
                    end else if (cnt == LONG_LAST) begin
                        state_nxt      = ST_HELD;
                        long_nxt       = 1'b1;
                        long_fired_nxt = 1'b1;
                        cnt_nxt        = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end

                ST_HELD: begin
                    if (!pressed) begin
                        state_nxt = ST_ARM_R;
                        cnt_nxt   = '0;
                    end
                end

                ST_ARM_R: begin
                    if (pressed) begin
                        // Bounce on release: the press continues. If the long
                        // pulse has not fired yet the long timer starts over,
                        // so a bouncy button cannot shorten the hold time.
                        state_nxt = long_fired ? ST_HELD : ST_PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt   = ST_IDLE;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                long_fired <= 1'b0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                state      <= state_nxt;
                cnt        <= cnt_nxt;
                long_fired <= long_fired_nxt;
                level_q    <= level_nxt;
                press_q    <= press_nxt;
                release_q  <= release_nxt;
                long_q     <= long_nxt;
            end
        end

        assign btn_level[g]     = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign long_pulse[g]    = long_q;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side companion to the LED pattern driver: conditions NUM_BTN raw, active-low, bouncing push-buttons into clean levels and single-cycle events.
- Events are press, release and long-press; downstream logic (LED pattern select, speed change) consumes them.
- Each button has its own 2-flop synchronizer, debounce/hold counter and 5-state FSM.
- All logic runs on clk_50M.

Parameters:
- NUM_BTN, 4, number of independent buttons.
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a press or release (20 ms at 50 MHz); legal range >= 2.
- LONG_CYCLES, 50000000, cycles after an accepted press before long_pulse fires (1 s); legal range >= 2.

Ports:
- clk_50M  input  1  50 MHz system clock.
- rst_n  input  1  asynchronous, active-low reset.
- btn_n  input  NUM_BTN  raw buttons, asynchronous to clk_50M; 0 = pressed.
- btn_level  output  NUM_BTN  debounced state; 1 = pressed.
- press_pulse  output  NUM_BTN  1-cycle pulse when a press is accepted.
- release_pulse  output  NUM_BTN  1-cycle pulse when a release is accepted.
- long_pulse  output  NUM_BTN  1-cycle pulse when a press has been held LONG_CYCLES.

Behaviour:
- Reset is asynchronous, active-low; clock is clk_50M.
- Reset values:
  - Synchronizer flops = 1 (released).
  - FSM = IDLE, counter = 0, long_fired = 0.
  - All outputs = 0.
- Synchronizer: 2 flops per bit; the FSM uses only the second flop (s2, inverted: p = ~s2).
- Counter width is $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)) bits. It never wraps; it is cleared on every state change.
- FSM per button:
  - IDLE: level 0. If p=1, go to ARM_P with cnt=0.
  - ARM_P:
    - If p=0, return to IDLE (glitch rejected, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED: btn_level<=1, press_pulse<=1, cnt<=0, long_fired<=0.
    - Otherwise cnt++.
  - PRESSED:
    - If p=0, go to ARM_R with cnt=0.
    - Else if cnt == LONG_CYCLES-1, go to HELD: long_pulse<=1, long_fired<=1.
    - Otherwise cnt++.
  - HELD: if p=0, go to ARM_R with cnt=0. No further long pulses while held.
  - ARM_R:
    - If p=1 (bounce on release): go to HELD if long_fired, else to PRESSED with cnt=0. The long timer restarts from 0 in that case. No pulse is generated.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE: btn_level<=0, release_pulse<=1.
    - Otherwise cnt++.
- Pulses are registered, exactly 1 cycle wide, and cleared the following cycle.
- At most one of press_pulse, release_pulse or long_pulse is high per button per cycle.
- Latency:
  - Edge 0 is the first clk edge that samples btn_n=0.
  - press_pulse and btn_level rise after edge DEBOUNCE_CYCLES+2, given btn_n is held stable.
  - long_pulse follows press_pulse by exactly LONG_CYCLES cycles.
  - Release timing is symmetric: release_pulse rises DEBOUNCE_CYCLES+2 edges after the first edge sampling btn_n=1.
- Buttons are fully independent. Simultaneous events on different bits each pulse in the same cycle.
- Reset mid-operation: everything returns to reset values immediately and no pulse is emitted.
  - If a button is held through reset deassertion, it is treated as a new press.
  - That press_pulse appears DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- btn_n glitches shorter than DEBOUNCE_CYCLES in any state produce no level change and no pulse.

Test Plan:
(All scenarios use NUM_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16.)
- Clean press on btn_n[0] held 10 cycles, then released -> press_pulse[0] high 1 cycle after edge 6; btn_level[0] 1 from then; release_pulse[0] 1 cycle, 6 edges after release; no long_pulse.
- Bounce: btn_n[1] toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> all outputs for bit 1 remain 0 throughout.
- Long press on btn_n[2] held 30 cycles -> press_pulse[2] after edge 6; long_pulse[2] exactly 16 cycles later, once only; release_pulse[2] on release.
- Release bounce: btn_n[0] held 8 cycles, then 2 cycles high, then low again for 20 cycles -> single press_pulse; no release_pulse; long_pulse fires 16 cycles after the PRESSED re-entry.
- Simultaneous: btn_n[3:0]=4'b0000 applied on the same edge -> press_pulse=4'b1111 in the same cycle; btn_level=4'b1111.
- Reset mid-press: assert rst_n=0 while btn_level[1]=1 and btn_n[1] is held low, then deassert -> outputs 0 during reset, no release_pulse; press_pulse[1] is 1 cycle, 6 edges after deassertion.
